gen_gray_counter_ud: RTL and testbench
======================================

# gen_gray_counter_ud

Parametrised up/down Gray-code counter with synchronous clear, binary parallel load, and selectable wrap or saturate mode. It provides glitch-free registered Gray and binary views of the same count, plus terminal flags. It is the building block for async-FIFO pointers and the clock-domain-crossing address and credit counters in the AXI/XSPI slave path. Only the Gray output is safe to synchronise into another clock domain.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = hold at the end values.
- INIT, 0, binary value loaded on reset; must be < 2^WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear to binary 0.
- load  input  1  synchronous parallel load from load_val.
- load_val  input  WIDTH  binary value to load.
- enable  input  1  count-step enable.
- up  input  1  direction: 1 = increment, 0 = decrement; ignored when enable=0.
- count_gray  output  WIDTH  Gray code of the current count, driven directly from a flop.
- count_bin  output  WIDTH  binary current count, registered.
- at_max  output  1  registered; 1 when count_bin is all ones.
- at_min  output  1  registered; 1 when count_bin is 0.
- wrap  output  1  registered one-cycle pulse, set the cycle after a wrapping step.

## Operation
- State is held in two flop sets, bin_q and gray_q, with the invariant gray_q = bin_q ^ (bin_q >> 1).
- The next binary value is computed combinationally from bin_q. The Gray value is derived from the next binary value before the flop, so count_gray never passes through combinational logic.
- Per-cycle priority: clr > load > enable > hold.
  - clr: next = 0.
  - load: next = load_val.
  - enable && up: next = bin_q + 1, modulo 2^WIDTH.
  - enable && !up: next = bin_q - 1, modulo 2^WIDTH.
- SATURATE=1:
  - An increment when bin_q is all ones holds the value.
  - A decrement when bin_q is 0 holds the value.
  - wrap is never asserted.
- SATURATE=0:
  - Increment from all ones gives 0; decrement from 0 gives all ones.
  - Each such step registers wrap=1 for exactly one cycle.
- wrap is only produced by enable steps. clr and load never assert wrap, even when the value jumps across the boundary.
- at_max and at_min are computed from the next binary value and registered, so they are always coherent with count_bin in the same cycle.
- On a pure enable step, consecutive count_gray values differ in exactly one bit, including at the wrap. clr and load may change any number of bits; the user must not load while the far domain is sampling.

## Timing
- Reset (asynchronous assert, clocked release) sets:
  - bin_q = INIT, count_gray = INIT ^ (INIT >> 1).
  - at_max = (INIT == 2^WIDTH - 1), at_min = (INIT == 0), wrap = 0.
- Latency is 1 cycle: an action sampled at edge N is visible on all outputs after edge N.
- Back-to-back enable gives one step per cycle. A direction change takes effect on the very next step, with no bubble.
- Simultaneous events:
  - clr with load or enable: clear wins.
  - load with enable: load_val is taken without a step.
- Reset asserted mid-count overrides everything immediately, and wrap drops asynchronously. The first step after release starts from INIT.

## Test plan
- Reset values: WIDTH=4, INIT=5; hold reset → count_bin=0101, count_gray=0111, at_min=0, at_max=0, wrap=0.
- Up wrap: SATURATE=0, from 0 apply enable=1, up=1 for 16 cycles → count_bin 1..15 then 0. Every Gray step has Hamming distance 1. at_max=1 only while count_bin=15. wrap=1 only in the cycle count_bin returns to 0.
- Down wrap: from 0 apply enable=1, up=0 → count_bin=15, count_gray=1000, wrap=1 for one cycle, at_max=1.
- Load/clear priority: load=1, load_val=9, enable=1 → count_bin=9, count_gray=1101, no step. Then clr=1 with load=1 → count_bin=0, at_min=1, wrap=0.
- Saturate: SATURATE=1, count up 20 cycles from 0 → holds at 15, wrap never 1. Then count down 20 cycles → holds at 0, at_min=1.
- Async reset mid-operation: assert reset between edges while counting at 7 → outputs go to INIT values before the next edge. After release, the first step gives INIT+1.

Source files
------------

// File: rtl/gen_gray_counter_ud.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gen_gray_counter_ud: up/down Gray counter with clear, load, wrap/saturate. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gen_gray_counter_ud #(
  parameter int          WIDTH    = 4,
  parameter int          SATURATE = 0,
  parameter logic [31:0] INIT     = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count_gray,
  output logic [WIDTH-1:0] count_bin,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_max  = '1;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_init = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_init_gray = c_init ^ (c_init >> 1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_at_max;
  logic             r_at_min;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (clr) begin
      w_next_bin = c_zero;
    end else if (load) begin
      w_next_bin = load_val;
    end else if (enable) begin
      if (up) begin
        if (r_bin == c_max) begin
          if (SATURATE == 0) begin
            w_next_bin  = c_zero;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_bin = r_bin + c_one;
        end
      end else begin
        if (r_bin == c_zero) begin
          if (SATURATE == 0) begin
            w_next_bin  = c_max;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_bin = r_bin - c_one;
        end
      end
    end
  end

  // Gray is encoded before the flop so count_gray is a clean register output.
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin    <= c_init;
      r_gray   <= c_init_gray;
      r_at_max <= (c_init == c_max);
      r_at_min <= (c_init == c_zero);
      r_wrap   <= 1'b0;
    end else begin
      r_bin    <= w_next_bin;
      r_gray   <= w_next_gray;
      r_at_max <= (w_next_bin == c_max);
      r_at_min <= (w_next_bin == c_zero);
      r_wrap   <= w_next_wrap;
    end
  end

  assign count_bin  = r_bin;
  assign count_gray = r_gray;
  assign at_max     = r_at_max;
  assign at_min     = r_at_min;
  assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gen_gray_counter_ud.sv
`default_nettype none
// Randomised and directed check of gen_gray_counter_ud against an arithmetic
// model, across wrap/saturate variants and two widths.
module tb_gen_gray_counter_ud;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] lv = 8'd0;
  logic       enable = 1'b0;
  logic       up = 1'b0;

  logic [3:0] a_gray, a_bin, b_gray, b_bin;
  logic [7:0] c_gray, c_bin;
  logic       a_max, a_min, a_wrap, b_max, b_min, b_wrap, c_max, c_min, c_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gen_gray_counter_ud #(.WIDTH(4), .SATURATE(0), .INIT(32'd5)) u_a (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv[3:0]),
    .enable(enable), .up(up), .count_gray(a_gray), .count_bin(a_bin),
    .at_max(a_max), .at_min(a_min), .wrap(a_wrap));

  gen_gray_counter_ud #(.WIDTH(4), .SATURATE(1), .INIT(32'd5)) u_b (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv[3:0]),
    .enable(enable), .up(up), .count_gray(b_gray), .count_bin(b_bin),
    .at_max(b_max), .at_min(b_min), .wrap(b_wrap));

  gen_gray_counter_ud #(.WIDTH(8), .SATURATE(0), .INIT(32'd0)) u_c (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv),
    .enable(enable), .up(up), .count_gray(c_gray), .count_bin(c_bin),
    .at_max(c_max), .at_min(c_min), .wrap(c_wrap));

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count as an integer in [0, 2^w), compute the next value by rule.
  function automatic longint nxt(input longint v, input int w, input bit sat,
                                 output bit wr);
    longint top;
    top = (longint'(1) << w) - 1;
    wr  = 1'b0;
    if (clr) return 0;
    if (load) return longint'(lv) & top;
    if (!enable) return v;
    if (up) begin
      if (v < top) return v + 1;
      if (sat) return v;
      wr = 1'b1;
      return 0;
    end
    if (v > 0) return v - 1;
    if (sat) return v;
    wr = 1'b1;
    return top;
  endfunction

  longint ma = 5, mb = 5, mc = 0;
  bit     wa = 0, wb = 0, wc = 0;
  bit     sa = 0, sc = 0;
  logic [3:0] pa = 4'd0;
  logic [7:0] pc = 8'd0;

  always @(posedge clk or posedge reset) begin
    longint t;
    bit     w;
    if (reset) begin
      ma <= 5; mb <= 5; mc <= 0;
      wa <= 0; wb <= 0; wc <= 0;
      sa <= 0; sc <= 0;
    end else begin
      t = nxt(ma, 4, 1'b0, w);
      sa <= enable && !clr && !load && (t != ma);
      pa <= a_gray;
      ma <= t; wa <= w;
      t = nxt(mb, 4, 1'b1, w);
      mb <= t; wb <= w;
      t = nxt(mc, 8, 1'b0, w);
      sc <= enable && !clr && !load && (t != mc);
      pc <= c_gray;
      mc <= t; wc <= w;
    end
  end

  task automatic cmp_inst(input string tag, input longint bin, input longint gray,
                          input bit mx, input bit mn, input bit wr,
                          input longint mv, input bit mw, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    chk({tag, ".count_bin"}, bin, mv);
    chk({tag, ".count_gray"}, gray, mv ^ (mv >> 1));
    chk({tag, ".at_max"}, longint'(mx), longint'(mv == top));
    chk({tag, ".at_min"}, longint'(mn), longint'(mv == 0));
    chk({tag, ".wrap"}, longint'(wr), longint'(mw));
  endtask

  always @(negedge clk) begin
    cmp_inst("a", a_bin, a_gray, a_max, a_min, a_wrap, ma, wa, 4);
    cmp_inst("b", b_bin, b_gray, b_max, b_min, b_wrap, mb, wb, 4);
    cmp_inst("c", c_bin, c_gray, c_max, c_min, c_wrap, mc, wc, 8);
    if (!reset && sa) chk("a.gray_hamming", $countones(a_gray ^ pa), 1);
    if (!reset && sc) chk("c.gray_hamming", $countones(c_gray ^ pc), 1);
  end

  // Drive one cycle of inputs just after a falling edge, then wait for the
  // next falling edge (+1) so the result of that rising edge is visible.
  task automatic cyc(input bit c, input bit l, input logic [7:0] v,
                     input bit e, input bit u);
    clr = c; load = l; lv = v; enable = e; up = u;
    @(negedge clk); #1;
  endtask

  initial begin
    @(negedge clk); @(negedge clk); #1;
    chk("reset.a_bin", a_bin, 5);
    chk("reset.a_gray", a_gray, 4'b0111);
    chk("reset.a_min", a_min, 0);
    chk("reset.a_max", a_max, 0);
    chk("reset.a_wrap", a_wrap, 0);
    chk("reset.c_min", c_min, 1);
    reset = 1'b0;

    cyc(1, 0, 0, 0, 0);
    chk("clr.a_bin", a_bin, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("upwrap.a_bin", a_bin, (i + 1) % 16);
      chk("upwrap.a_wrap", a_wrap, (i == 15));
      chk("upwrap.a_max", a_max, (i == 14));
    end
    cyc(0, 0, 0, 1, 0);
    chk("downwrap.a_bin", a_bin, 15);
    chk("downwrap.a_gray", a_gray, 4'b1000);
    chk("downwrap.a_wrap", a_wrap, 1);
    chk("downwrap.a_max", a_max, 1);
    cyc(0, 0, 0, 0, 0);
    chk("hold.a_wrap", a_wrap, 0);

    cyc(0, 1, 8'd9, 1, 1);
    chk("load.a_bin", a_bin, 9);
    chk("load.a_gray", a_gray, 4'b1101);
    cyc(1, 1, 8'd9, 1, 1);
    chk("clrload.a_bin", a_bin, 0);
    chk("clrload.a_min", a_min, 1);
    chk("clrload.a_wrap", a_wrap, 0);

    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("satup.b_wrap", b_wrap, 0);
    end
    chk("satup.b_bin", b_bin, 15);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("satdn.b_wrap", b_wrap, 0);
    end
    chk("satdn.b_bin", b_bin, 0);
    chk("satdn.b_min", b_min, 1);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
          8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end

    // Reset landing mid-cycle while the wrap pulse is high.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 1);
    chk("prewrap.a_wrap", a_wrap, 1);
    reset = 1'b1; #1;
    chk("asyncwrap.a_wrap", a_wrap, 0);
    chk("asyncwrap.a_bin", a_bin, 5);
    @(negedge clk); #1;
    reset = 1'b0;

    // Reset landing mid-cycle while counting at 7.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 1);
    chk("at7.a_bin", a_bin, 7);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("async7.a_bin", a_bin, 5);
    chk("async7.a_gray", a_gray, 4'b0111);
    chk("async7.a_wrap", a_wrap, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    cyc(0, 0, 0, 1, 1);
    chk("release.a_bin", a_bin, 6);
    chk("release.c_bin", c_bin, 1);

    cyc(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
